fnd_scan_decoder: RTL and testbench

Receive-side counterpart of the board's 7-segment (FND) display drivers. It samples the multiplexed FND bus: active-low segments `fnd[6:0]` and active-low digit selects `fndsel[3:0]`. It qualifies each digit slot with a stability filter, decodes each segment pattern back to a digit code, and presents four captured digits plus status. It sits beside any FND driver in the design and serves as an on-chip display monitor and self-check for counter/display blocks.

---
 rtl/fnd_pkg.sv | 20 ++
 rtl/seg7_to_code.sv | 31 +++
 rtl/fnd_scan_decoder.sv | 129 ++++++++++++
 tb/tb_fnd_scan_decoder.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared FND constants: active-low segment patterns {g,f,e,d,c,b,a} and digit codes.
package fnd_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] CODE_BLANK = 4'hA;

    localparam int unsigned NUM_DIGITS = 4;

endpackage

// File: rtl/seg7_to_code.sv
// Combinational segment-pattern decoder: maps an active-low pattern to a digit code,
// flagging anything that is not 0-9 or blank.
module seg7_to_code
    import fnd_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] code,
    output logic       illegal
);

    // Pattern lookup; unknown patterns report illegal with a don't-care code of 0
    always_comb begin
        code    = 4'h0;
        illegal = 1'b0;
        case (seg)
            SEG_0:     code = 4'd0;
            SEG_1:     code = 4'd1;
            SEG_2:     code = 4'd2;
            SEG_3:     code = 4'd3;
            SEG_4:     code = 4'd4;
            SEG_5:     code = 4'd5;
            SEG_6:     code = 4'd6;
            SEG_7:     code = 4'd7;
            SEG_8:     code = 4'd8;
            SEG_9:     code = 4'd9;
            SEG_BLANK: code = CODE_BLANK;
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/fnd_scan_decoder.sv
// FND bus monitor: samples the multiplexed display bus, qualifies each digit slot with a
// stability filter, decodes the segment pattern and holds four captured digits plus status.
module fnd_scan_decoder
    import fnd_pkg::*;
#(
    parameter int unsigned STABLE_CYC = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            fnd,
    input  logic [3:0]            fndsel,
    output logic [3:0]            digit0,
    output logic [3:0]            digit1,
    output logic [3:0]            digit2,
    output logic [3:0]            digit3,
    output logic [NUM_DIGITS-1:0] digit_valid,
    output logic [NUM_DIGITS-1:0] digit_err,
    output logic                  frame_done
);

    localparam logic [3:0] CntMax = 4'(STABLE_CYC);
    localparam logic [3:0] CntCap = 4'(STABLE_CYC - 1);

    logic [6:0]            s_fnd;
    logic [3:0]            s_sel;
    logic [3:0]            cnt, cnt_d;
    logic                  in_match;
    logic                  sel_legal;
    logic [1:0]            sel_idx;
    logic                  capture;
    logic [3:0]            dec_code;
    logic                  dec_illegal;
    logic [NUM_DIGITS-1:0] sel_onehot;

    logic [3:0]            digit_q [NUM_DIGITS];
    logic [3:0]            digit_d [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] valid_q, valid_d;
    logic [NUM_DIGITS-1:0] err_q, err_d;
    logic [NUM_DIGITS-1:0] seen_q, seen_d;
    logic                  frame_q, frame_d;

    assign in_match = (fnd == s_fnd) && (fndsel == s_sel);

    // Stability counter: restarts on any change, saturates so a held value never recaptures
    always_comb begin
        cnt_d = 4'd0;
        if (in_match) begin
            cnt_d = (cnt == CntMax) ? cnt : cnt + 4'd1;
        end
    end

    // Select legality and index: exactly one active-low select bit
    always_comb begin
        sel_legal = 1'b1;
        sel_idx   = 2'd0;
        case (s_sel)
            4'b1110: sel_idx = 2'd0;
            4'b1101: sel_idx = 2'd1;
            4'b1011: sel_idx = 2'd2;
            4'b0111: sel_idx = 2'd3;
            default: sel_legal = 1'b0;
        endcase
    end

    assign capture    = in_match && (cnt == CntCap) && sel_legal;
    assign sel_onehot = NUM_DIGITS'(1) << sel_idx;

    // One decoder shared by all digit slots; the sampled pattern belongs to the selected digit
    seg7_to_code u_seg7_to_code (
        .seg     (s_fnd),
        .code    (dec_code),
        .illegal (dec_illegal)
    );

    // Capture next-state: digit/valid/err update, seen-mask accumulation and frame completion
    always_comb begin
        digit_d = digit_q;
        valid_d = valid_q;
        err_d   = err_q;
        seen_d  = seen_q;
        frame_d = 1'b0;
        if (capture) begin
            if (dec_illegal) begin
                err_d[sel_idx] = 1'b1;
            end else begin
                digit_d[sel_idx] = dec_code;
                valid_d[sel_idx] = 1'b1;
                err_d[sel_idx]   = 1'b0;
            end
            seen_d = seen_q | sel_onehot;
            if (&seen_d) begin
                frame_d = 1'b1;
                seen_d  = '0;
            end
        end
    end

    // State registers with synchronous reset; idle-bus sample values force a full window after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            s_fnd   <= SEG_BLANK;
            s_sel   <= 4'b1111;
            cnt     <= 4'd0;
            digit_q <= '{default: 4'h0};
            valid_q <= '0;
            err_q   <= '0;
            seen_q  <= '0;
            frame_q <= 1'b0;
        end else begin
            s_fnd   <= fnd;
            s_sel   <= fndsel;
            cnt     <= cnt_d;
            digit_q <= digit_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            seen_q  <= seen_d;
            frame_q <= frame_d;
        end
    end

    assign digit0      = digit_q[0];
    assign digit1      = digit_q[1];
    assign digit2      = digit_q[2];
    assign digit3      = digit_q[3];
    assign digit_valid = valid_q;
    assign digit_err   = err_q;
    assign frame_done  = frame_q;

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Scoreboard bench: each directed step queues its expected output state tagged with the
// clock edge after which it must hold; a negedge monitor pops and compares.
module tb_fnd_scan_decoder;
    import fnd_pkg::*;

    localparam int unsigned STABLE = 4;

    logic       clk;
    logic       rst;
    logic [6:0] fnd;
    logic [3:0] fndsel;
    logic [3:0] digit0, digit1, digit2, digit3;
    logic [3:0] digit_valid, digit_err;
    logic       frame_done;

    fnd_scan_decoder #(
        .STABLE_CYC (STABLE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fnd         (fnd),
        .fndsel      (fndsel),
        .digit0      (digit0),
        .digit1      (digit1),
        .digit2      (digit2),
        .digit3      (digit3),
        .digit_valid (digit_valid),
        .digit_err   (digit_err),
        .frame_done  (frame_done)
    );

    typedef struct {
        int          cyc;
        logic [15:0] dig;
        logic [3:0]  val;
        logic [3:0]  err;
        logic        frm;
        string       name;
    } exp_t;

    exp_t        q[$];
    int          edge_n   = 0;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_frames = 0;
    logic [15:0] prev_dig = '0;
    logic [3:0]  prev_val = '0;
    logic [3:0]  prev_err = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            edge_n++;
        end
    end

    // Monitor: compare every queued expectation due at this edge count
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= edge_n) begin
                e = q.pop_front();
                n_checks++;
                if (e.cyc < edge_n) begin
                    n_fail++;
                    $display("FAIL %s: check at edge %0d missed (now %0d)", e.name, e.cyc, edge_n);
                end else if ({digit3, digit2, digit1, digit0} !== e.dig || digit_valid !== e.val ||
                             digit_err !== e.err || frame_done !== e.frm) begin
                    n_fail++;
                    $display("FAIL %s: got dig=%h val=%b err=%b frm=%b, want dig=%h val=%b err=%b frm=%b",
                             e.name, {digit3, digit2, digit1, digit0}, digit_valid, digit_err,
                             frame_done, e.dig, e.val, e.err, e.frm);
                end
            end
            if (frame_done === 1'b1) n_frames++;
        end
    end

    // Apply one input value for 'hold' cycles; called just after a rising edge.
    // With cap set, the state is checked one edge before the capture edge (unchanged),
    // at the capture edge, and at the end of the hold (frame_done back low).
    task automatic step(input logic r, input logic [3:0] sel, input logic [6:0] seg,
                        input int hold, input logic cap, input logic [15:0] dig,
                        input logic [3:0] val, input logic [3:0] err, input logic frm,
                        input string name);
        int   n0;
        exp_t e;
        n0     = edge_n;
        rst    = r;
        fndsel = sel;
        fnd    = seg;
        if (cap) begin
            e = '{cyc: n0 + STABLE, dig: prev_dig, val: prev_val, err: prev_err, frm: 1'b0,
                  name: {name, " pre"}};
            q.push_back(e);
            e = '{cyc: n0 + STABLE + 1, dig: dig, val: val, err: err, frm: frm, name: name};
            q.push_back(e);
        end
        e = '{cyc: n0 + hold, dig: dig, val: val, err: err, frm: 1'b0, name: {name, " end"}};
        q.push_back(e);
        repeat (hold) @(posedge clk);
        #1;
        rst      = 1'b0;
        prev_dig = dig;
        prev_val = val;
        prev_err = err;
    endtask

    initial begin
        rst    = 1'b1;
        fnd    = SEG_BLANK;
        fndsel = 4'b1111;
        @(posedge clk);
        #1;
        step(1'b1, 4'b1111, SEG_BLANK, 2, 1'b0, 16'h0000, 4'b0000, 4'b0000, 1'b0, "reset");

        // Single digit held 10 cycles: one capture at E4
        step(1'b0, 4'b1110, SEG_3, 10, 1'b1, 16'h0003, 4'b0001, 4'b0000, 1'b0, "d0=3");

        // First scan 2,0,7,blank
        step(1'b0, 4'b1110, SEG_2,     6, 1'b1, 16'h0002, 4'b0001, 4'b0000, 1'b0, "scan1 d0");
        step(1'b0, 4'b1101, SEG_0,     6, 1'b1, 16'h0002, 4'b0011, 4'b0000, 1'b0, "scan1 d1");
        step(1'b0, 4'b1011, SEG_7,     6, 1'b1, 16'h0702, 4'b0111, 4'b0000, 1'b0, "scan1 d2");
        step(1'b0, 4'b0111, SEG_BLANK, 6, 1'b1, 16'hA702, 4'b1111, 4'b0000, 1'b1, "scan1 d3");

        // Second scan 5,9,6,1
        step(1'b0, 4'b1110, SEG_5, 6, 1'b1, 16'hA705, 4'b1111, 4'b0000, 1'b0, "scan2 d0");
        step(1'b0, 4'b1101, SEG_9, 6, 1'b1, 16'hA795, 4'b1111, 4'b0000, 1'b0, "scan2 d1");
        step(1'b0, 4'b1011, SEG_6, 6, 1'b1, 16'hA695, 4'b1111, 4'b0000, 1'b0, "scan2 d2");
        step(1'b0, 4'b0111, SEG_1, 6, 1'b1, 16'h1695, 4'b1111, 4'b0000, 1'b1, "scan2 d3");

        // Glitch on digit 1: 3 cycles of 2, one of 1, then 2 again
        step(1'b0, 4'b1101, SEG_2, 3, 1'b0, 16'h1695, 4'b1111, 4'b0000, 1'b0, "glitch lead");
        step(1'b0, 4'b1101, SEG_1, 1, 1'b0, 16'h1695, 4'b1111, 4'b0000, 1'b0, "glitch pulse");
        step(1'b0, 4'b1101, SEG_2, 6, 1'b1, 16'h1625, 4'b1111, 4'b0000, 1'b0, "glitch settle");

        // Illegal pattern on digit 2, then a legal 8
        step(1'b0, 4'b1011, 7'b0101010, 6, 1'b1, 16'h1625, 4'b1111, 4'b0100, 1'b0, "illegal d2");
        step(1'b0, 4'b1011, SEG_8,      6, 1'b1, 16'h1825, 4'b1111, 4'b0000, 1'b0, "d2=8");

        // Two selects low, then none low: no capture
        step(1'b0, 4'b1100, SEG_8, 8, 1'b0, 16'h1825, 4'b1111, 4'b0000, 1'b0, "two sel");
        step(1'b0, 4'b1111, SEG_8, 8, 1'b0, 16'h1825, 4'b1111, 4'b0000, 1'b0, "no sel");

        // Seen mask is now {1,2}; add digit 0 so three are seen, then reset
        step(1'b0, 4'b1110, SEG_3, 6, 1'b1, 16'h1823, 4'b1111, 4'b0000, 1'b0, "pre-rst d0");
        step(1'b1, 4'b1111, SEG_BLANK, 1, 1'b0, 16'h0000, 4'b0000, 4'b0000, 1'b0, "mid reset");

        // Digit 3 first: a stale mask would complete the frame here
        step(1'b0, 4'b0111, SEG_7, 6, 1'b1, 16'h7000, 4'b1000, 4'b0000, 1'b0, "post d3");
        step(1'b0, 4'b1110, SEG_4, 6, 1'b1, 16'h7004, 4'b1001, 4'b0000, 1'b0, "post d0");
        step(1'b0, 4'b1101, SEG_5, 6, 1'b1, 16'h7054, 4'b1011, 4'b0000, 1'b0, "post d1");
        step(1'b0, 4'b1011, SEG_6, 6, 1'b1, 16'h7654, 4'b1111, 4'b0000, 1'b1, "post d2");

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        n_checks++;
        if (n_frames != 3) begin
            n_fail++;
            $display("FAIL frame count: got %0d pulses, want 3", n_frames);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
